// File: rtl/instruction_fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Fetch FSM states, the reset PC and the instruction word type.
package instruction_fetch_pkg;

  typedef logic [31:0] int_t;

  typedef enum logic [1:0] {
    REQUEST = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam int_t RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/fetch_output_slot.sv
// Single-entry valid/ready holding register feeding decode.
// Ports: load/load_data/load_pc fill it, consume drains it, flush empties it.
module fetch_output_slot
  import instruction_fetch_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  int_t load_data,
  input  int_t load_pc,
  input  logic consume,
  input  logic flush,
  output logic valid,
  output int_t data,
  output int_t pc
);

  // flush beats load beats consume
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end else if (valid && consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, one outstanding imem fetch, one output slot.
// Optional FETCH_PERF_COUNTERS_EN adds fetchCount/discardCount outputs.
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic        imemRequestValid,
  input  logic        imemRequestReady,
  output int_t        imemRequestAddress,
  input  logic        imemResponseValid,
  input  int_t        imemResponseData,
  input  logic        redirectValid,
  input  int_t        redirectTarget,
  output logic        outValid,
  input  logic        outReady,
  output int_t        outInstructionData,
`ifdef FETCH_PERF_COUNTERS_EN
  output int_t        outPc,
  output logic [31:0] fetchCount,
  output logic [31:0] discardCount
`else
  output int_t        outPc
`endif
);

  fetch_state_t state;
  fetch_state_t state_next;
  int_t         pc;
  int_t         in_flight_pc;
  logic         slot_free;
  logic         req_valid;
  logic         fire;
  logic         load;
  logic         drop;
  logic         unused_tgt;

  assign unused_tgt = ^redirectTarget[1:0];
  assign slot_free  = !outValid || outReady;

  always_comb begin
    state_next = state;
    req_valid  = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    unique case (state)
      REQUEST: begin
        req_valid = slot_free && !redirectValid;
        if (req_valid && imemRequestReady)
          state_next = WAIT;
      end
      WAIT: begin
        if (imemResponseValid) begin
          load       = !redirectValid;
          drop       = redirectValid;
          state_next = REQUEST;
        end else if (redirectValid) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (imemResponseValid) begin
          drop       = 1'b1;
          state_next = REQUEST;
        end
      end
      default: state_next = REQUEST;
    endcase
  end

  // async reset puts us in REQUEST; hold the request low until release
  assign imemRequestValid   = req_valid && !reset;
  assign imemRequestAddress = pc;
  assign fire = req_valid && imemRequestReady;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= REQUEST;
      pc           <= RESET_PC;
      in_flight_pc <= '0;
    end else begin
      state <= state_next;
      if (redirectValid) begin
        pc <= {redirectTarget[31:2], 2'b00};
      end else if (fire) begin
        pc <= pc + 32'd4;
      end
      if (fire)
        in_flight_pc <= pc;
    end
  end

  fetch_output_slot u_slot (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_data (imemResponseData),
    .load_pc   (in_flight_pc),
    .consume   (outReady),
    .flush     (redirectValid),
    .valid     (outValid),
    .data      (outInstructionData),
    .pc        (outPc)
  );

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] discard_inc;

  assign discard_inc = 32'(drop) + 32'(outValid && redirectValid);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetchCount   <= '0;
      discardCount <= '0;
    end else begin
      if (outValid && outReady)
        fetchCount <= fetchCount + 32'd1;
      discardCount <= discardCount + discard_inc;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch.
// Inputs change 1ns after the rising edge; outputs checked 2ns after.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imemRequestValid;
  logic        imemRequestReady = 1'b1;
  logic [31:0] imemRequestAddress;
  logic        imemResponseValid = 1'b0;
  logic [31:0] imemResponseData = '0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectTarget = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] outInstructionData;
  logic [31:0] outPc;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetchCount;
  logic [31:0] discardCount;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  instruction_fetch dut (
    .clock              (clock),
    .reset              (reset),
    .imemRequestValid   (imemRequestValid),
    .imemRequestReady   (imemRequestReady),
    .imemRequestAddress (imemRequestAddress),
    .imemResponseValid  (imemResponseValid),
    .imemResponseData   (imemResponseData),
    .redirectValid      (redirectValid),
    .redirectTarget     (redirectTarget),
    .outValid           (outValid),
    .outReady           (outReady),
    .outInstructionData (outInstructionData),
`ifdef FETCH_PERF_COUNTERS_EN
    .outPc              (outPc),
    .fetchCount         (fetchCount),
    .discardCount       (discardCount)
`else
    .outPc              (outPc)
`endif
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic resp(input logic v, input logic [31:0] d);
    imemResponseValid = v;
    imemResponseData  = d;
  endtask

  initial begin
    // reset state
    @(posedge clock);
    #1;
    settle();
    check("rst_req_valid", 32'(imemRequestValid), 0);
    check("rst_out_valid", 32'(outValid), 0);
    check("rst_out_pc", outPc, 0);
    check("rst_out_data", outInstructionData, 0);
`ifdef FETCH_PERF_COUNTERS_EN
    check("rst_fetch_cnt", fetchCount, 0);
    check("rst_disc_cnt", discardCount, 0);
`endif
    reset = 1'b0;
    settle();
    check("req0_valid", 32'(imemRequestValid), 1);
    check("req0_addr", imemRequestAddress, 32'h3000);
    tick();
    // WAIT: response k=1
    resp(1, mem(32'h3000));
    settle();
    check("wait_no_req", 32'(imemRequestValid), 0);
    check("wait_no_out", 32'(outValid), 0);
    tick();
    resp(0, 0);
    settle();
    check("out0_valid", 32'(outValid), 1);
    check("out0_pc", outPc, 32'h3000);
    check("out0_data", outInstructionData, 32'h1357_ABDF);
    check("req1_addr", imemRequestAddress, 32'h3004);
    check("req1_valid", 32'(imemRequestValid), 1);
    tick();
    resp(1, mem(32'h3004));
    settle();
    check("gap1_out", 32'(outValid), 0);
    tick();
    resp(0, 0);
    settle();
    check("out1_valid", 32'(outValid), 1);
    check("out1_pc", outPc, 32'h3004);
    check("out1_data", outInstructionData, mem(32'h3004));
    check("req2_addr", imemRequestAddress, 32'h3008);
    tick();
    resp(1, mem(32'h3008));
    settle();
    check("gap2_out", 32'(outValid), 0);
    tick();
    resp(0, 0);
    // back-pressure: decode stalls five cycles
    outReady = 1'b0;
    settle();
    check("out2_pc", outPc, 32'h3008);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(outValid), 1);
      check("stall_data", outInstructionData, mem(32'h3008));
      check("stall_no_req", 32'(imemRequestValid), 0);
      tick();
    end
    outReady = 1'b1;
    settle();
    check("stall_pc_hold", outPc, 32'h3008);
    check("resume_req", 32'(imemRequestValid), 1);
    check("resume_addr", imemRequestAddress, 32'h300C);
    tick();
    // redirect in WAIT, response two cycles later
    redirectValid  = 1'b1;
    redirectTarget = 32'h0040_0010;
    settle();
    check("redir_no_req", 32'(imemRequestValid), 0);
    tick();
    redirectValid = 1'b0;
    settle();
    check("disc_no_req", 32'(imemRequestValid), 0);
    tick();
    resp(1, mem(32'h300C));
    settle();
    check("disc_no_req2", 32'(imemRequestValid), 0);
    tick();
    resp(0, 0);
    settle();
    check("drop_no_out", 32'(outValid), 0);
    check("tgt_req_valid", 32'(imemRequestValid), 1);
    check("tgt_req_addr", imemRequestAddress, 32'h0040_0010);
`ifdef FETCH_PERF_COUNTERS_EN
    check("cnt_fetch3", fetchCount, 3);
    check("cnt_disc1", discardCount, 1);
`endif
    tick();
    resp(1, mem(32'h0040_0010));
    tick();
    resp(0, 0);
    settle();
    check("tgt_out_valid", 32'(outValid), 1);
    check("tgt_out_pc", outPc, 32'h0040_0010);
    check("tgt_out_data", outInstructionData, mem(32'h0040_0010));
    check("tgt_next_addr", imemRequestAddress, 32'h0040_0014);
    tick();
    // redirect coincident with response; low target bits ignored
    resp(1, mem(32'h0040_0014));
    redirectValid  = 1'b1;
    redirectTarget = 32'hFFFF_FFFE;
    tick();
    resp(0, 0);
    redirectValid = 1'b0;
    settle();
    check("coinc_no_out", 32'(outValid), 0);
    check("coinc_req", 32'(imemRequestValid), 1);
    check("coinc_addr", imemRequestAddress, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_COUNTERS_EN
    check("cnt_fetch4", fetchCount, 4);
    check("cnt_disc2", discardCount, 2);
`endif
    tick();
    resp(1, mem(32'hFFFF_FFFC));
    tick();
    resp(0, 0);
    settle();
    check("top_out_pc", outPc, 32'hFFFF_FFFC);
    check("top_out_data", outInstructionData, mem(32'hFFFF_FFFC));
    check("wrap_addr", imemRequestAddress, 32'h0000_0000);
    check("wrap_req", 32'(imemRequestValid), 1);
    tick();
    // reset mid-fetch (WAIT on address 0)
    reset = 1'b1;
    settle();
    check("mid_rst_out", 32'(outValid), 0);
    check("mid_rst_req", 32'(imemRequestValid), 0);
    check("mid_rst_addr", imemRequestAddress, 32'h3000);
    tick();
    reset = 1'b0;
    resp(1, 32'hDEAD_BEEF);
    settle();
    check("post_rst_addr", imemRequestAddress, 32'h3000);
    tick();
    resp(0, 0);
    settle();
    check("stale_ignored", 32'(outValid), 0);
`ifdef FETCH_PERF_COUNTERS_EN
    check("cnt_post_rst", fetchCount, 0);
`endif
    resp(1, mem(32'h3000));
    tick();
    resp(0, 0);
    settle();
    check("post_rst_out", 32'(outValid), 1);
    check("post_rst_pc", outPc, 32'h3000);
    check("post_rst_data", outInstructionData, 32'h1357_ABDF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage directly upstream of the instruction decoder. Owns the program counter, issues word fetches to the instruction memory over a request/response handshake, and presents each fetched 32-bit instruction word plus its PC to the decode stage through a valid/ready output slot. Branch/jump resolution redirects the PC; in-flight and buffered fetches on the old path are discarded.

## Interface
- RESET_PC, 32'h0000_3000, PC loaded on reset; bits [1:0] must be 0
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- imemRequestValid  out  1  fetch request for imemRequestAddress
- imemRequestReady  in  1  memory accepts request this cycle
- imemRequestAddress  out  32  word-aligned fetch address (= pc)
- imemResponseValid  in  1  response data valid; always accepted, never back-pressured
- imemResponseData  in  32  fetched instruction word
- redirectValid  in  1  single-cycle PC redirect from branch resolution
- redirectTarget  in  32  new PC; bits [1:0] ignored (treated as 0)
- outValid  out  1  outInstructionData/outPc valid to decode
- outReady  in  1  decode consumes this cycle
- outInstructionData  out  32  int_t instruction word for the decoder
- outPc  out  32  address the word was fetched from

## Operation
- Registers: pc, inFlightPc, state, output slot (outValid, outInstructionData, outPc).
- slotFree = !outValid || outReady.
- States: REQUEST, WAIT, DISCARD.
- REQUEST: imemRequestValid = slotFree && !redirectValid. Handshake (valid && ready): inFlightPc <= pc, pc <= pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), go WAIT.
- WAIT: imemRequestValid = 0. imemResponseValid: slot <= {1, data, inFlightPc}, go REQUEST.
- DISCARD: imemRequestValid = 0. imemResponseValid: drop data, go REQUEST.
- Output slot: cleared (outValid <= 0) when outValid && outReady and no load same cycle; load overrides clear.
- Redirect (highest priority, any state): pc <= {redirectTarget[31:2], 2'b00}; outValid <= 0; no request issued that cycle.
  - REQUEST -> REQUEST.
  - WAIT without response -> DISCARD; WAIT with response same cycle -> response dropped, -> REQUEST.
  - DISCARD -> DISCARD (outstanding response still owed).
- At most one request outstanding; slot has room for every response by construction (request gated by slotFree).
- imemRequestValid may drop without handshake only on redirect; memory side must tolerate this.

## Timing
- Reset: pc = RESET_PC, state = REQUEST, outValid = 0, outInstructionData = 0, outPc = 0, inFlightPc = 0; imemRequestValid combinationally 1 only after reset deasserts.
- Fetch latency: request handshake cycle N, response cycle N+k (k >= 1), outValid visible cycle N+k+1.
- Peak throughput with k = 1 and outReady held high: one instruction per 2 cycles.
- Redirect in cycle N: first request to target earliest cycle N+1 (REQUEST) or after the owed response (DISCARD).
- Reset asserted mid-fetch: all state cleared immediately; a response arriving after reset release while in REQUEST is ignored.

## Configuration
- FETCH_PERF_COUNTERS_EN defined: adds outputs fetchCount (32, increments on each outValid && outReady) and discardCount (32, increments on each dropped response and each valid slot cleared by redirect; +2 if both same cycle); both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package: fetch_state_t enum (REQUEST, WAIT, DISCARD), RESET_PC default constant, reuse int_t from the common definitions.
- One sub-module: fetch_output_slot — single-entry valid/ready holding register with load, consume and flush inputs.

## Test plan
- Reset, imem ready always, k = 1, outReady = 1 -> outPc sequence 0x3000, 0x3004, 0x3008 with matching data, outValid every 2nd cycle.
- outReady held 0 for 5 cycles after first output -> outValid stays 1, data stable, imemRequestValid = 0, no second request until outReady = 1.
- Redirect to 0x0040_0010 while in WAIT, response arrives 2 cycles later -> response dropped, next imemRequestAddress = 0x0040_0010, outPc of next output = 0x0040_0010.
- Redirect coincident with response in WAIT -> no output, next request address = target immediately following cycle.
- pc = 0xFFFF_FFFC fetched -> next request address 0x0000_0000.
- With FETCH_PERF_COUNTERS_EN: 3 consumed fetches plus one discarded response -> fetchCount = 3, discardCount = 1.
